// File: rtl/frame_tx_scheduler.sv
// Two-requester frame transmit scheduler: round-robin grant, one-cycle strobe to the
// serial link, PC confirmation handling with bounded retransmit, timeout and idle gap.
module frame_tx_scheduler #(
    parameter int FRAME_SIZE = 16,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 4096,
    parameter int GAP        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [FRAME_SIZE*8-1:0] frame0,
    input  logic [FRAME_SIZE*8-1:0] frame1,
    output logic                    done0,
    output logic                    done1,
    output logic [1:0]              status,
    output logic [FRAME_SIZE*8-1:0] fin,
    output logic                    fin_valid,
    input  logic                    rx_busy,
    input  logic [7:0]              conf_code,
    input  logic                    conf_valid,
    output logic                    busy
);
    localparam int FW  = FRAME_SIZE * 8;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP + 1);
    localparam int RW  = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_FATAL   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE, ARB, SEND, WAIT_CONF, GAP_WAIT, REPORT
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   fin_q, fin_d;
    logic            fin_valid_q, fin_valid_d;
    logic            done0_q, done0_d, done1_q, done1_d;
    logic [1:0]      status_q, status_d;
    logic [1:0]      result_q, result_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic            retx_q, retx_d;
    logic            conf_q;
    logic            conf_edge;

    assign conf_edge = conf_valid & ~conf_q;

    always_comb begin
        state_d     = state_q;
        fin_d       = fin_q;
        fin_valid_d = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        status_d    = status_q;
        result_d    = result_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        retx_d      = retx_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) state_d = ARB;
            end
            ARB: begin
                if (req0 || req1) begin
                    // Contention goes to whoever was not served last.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    fin_d   = gnt_d ? frame1 : frame0;
                    retry_d = '0;
                    retx_d  = 1'b0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!rx_busy) begin
                    fin_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = WAIT_CONF;
                end
            end
            WAIT_CONF: begin
                // A confirmation edge takes precedence over a coincident timeout.
                if (conf_edge) begin
                    gap_d   = '0;
                    state_d = GAP_WAIT;
                    case (conf_code)
                        8'h05: result_d = ST_OK;
                        8'h08: result_d = ST_FATAL;
                        default: begin
                            if (retry_q < RW'(MAX_RETRY)) begin
                                retry_d = retry_q + 1'b1;
                                retx_d  = 1'b1;
                            end else begin
                                result_d = ST_ERROR;
                            end
                        end
                    endcase
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    result_d = ST_TIMEOUT;
                    gap_d    = '0;
                    state_d  = GAP_WAIT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            GAP_WAIT: begin
                if (gap_q == GW'(GAP - 1)) begin
                    if (retx_q) begin
                        retx_d  = 1'b0;
                        state_d = SEND;
                    end else begin
                        done0_d  = ~gnt_q;
                        done1_d  = gnt_q;
                        status_d = result_q;
                        state_d  = REPORT;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            REPORT: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fin_q       <= '0;
            fin_valid_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            status_q    <= ST_OK;
            result_q    <= ST_OK;
            retry_q     <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            retx_q      <= 1'b0;
            conf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fin_q       <= fin_d;
            fin_valid_q <= fin_valid_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            status_q    <= status_d;
            result_q    <= result_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            retx_q      <= retx_d;
            conf_q      <= conf_valid;
        end
    end

    assign fin       = fin_q;
    assign fin_valid = fin_valid_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign status    = status_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler: arbitration, retries, timeout, fatal,
// rx_busy hold-off and mid-transfer reset, with hand-derived cycle counts.
module tb_frame_tx_scheduler;
    localparam int FRAME_SIZE = 16;
    localparam int MAX_RETRY  = 3;
    localparam int TIMEOUT    = 100;
    localparam int GAP        = 6;
    localparam int FW         = FRAME_SIZE * 8;
    localparam int LIM        = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [FW-1:0] frame0, frame1;
    logic          done0, done1;
    logic [1:0]    status;
    logic [FW-1:0] fin;
    logic          fin_valid;
    logic          rx_busy;
    logic [7:0]    conf_code;
    logic          conf_valid;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int fv_total = 0;
    int dn_total = 0;

    frame_tx_scheduler #(
        .FRAME_SIZE(FRAME_SIZE), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .frame0(frame0), .frame1(frame1), .done0(done0), .done1(done1),
        .status(status), .fin(fin), .fin_valid(fin_valid), .rx_busy(rx_busy),
        .conf_code(conf_code), .conf_valid(conf_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fin_valid) fv_total++;
        if (done0 || done1) dn_total++;
    end

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fv(output int n);
        n = 0;
        do begin tick(); n++; end while (!fin_valid && n < LIM);
        if (!fin_valid) n = -1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin tick(); n++; end while (!(done0 || done1) && n < LIM);
        if (!(done0 || done1)) n = -1;
    endtask

    task automatic reply(input logic [7:0] code);
        conf_code  = code;
        conf_valid = 1'b1;
        tick();
        conf_valid = 1'b0;
    endtask

    logic [FW-1:0] fa, fb, fc;
    int n, base, quiet;

    initial begin
        fa = 128'h000102030405060708090A0B0C0D0E0F;
        fb = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        fc = 128'h55AA55AA0123456789ABCDEFFEDCBA98;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; frame0 = fa; frame1 = fb;
        rx_busy = 1'b0; conf_code = 8'h00; conf_valid = 1'b0;
        #1;
        check("rst_fin", fin, '0);
        check("rst_fv", FW'(fin_valid), FW'(1'b0));
        check("rst_done", FW'({done0, done1}), FW'(2'b00));
        check("rst_busy", FW'(busy), FW'(1'b0));
        check("rst_status", FW'(status), FW'(2'b00));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous pair from reset: req0 wins, then req1 (req0 re-requests), then req0.
        req0 = 1'b1; req1 = 1'b1;
        wait_fv(n);
        check("pair_lat", FW'(n), FW'(3));
        check("pair_fin0", fin, fa);
        reply(8'h05);
        wait_done(n);
        check("pair_done0_lat", FW'(n), FW'(GAP));
        check("pair_done_sel0", FW'({done0, done1}), FW'(2'b10));
        frame0 = fc;
        wait_fv(n);
        check("pair2_lat", FW'(n), FW'(4));
        check("pair2_fin1", fin, fb);
        reply(8'h05);
        wait_done(n);
        check("pair2_done_sel1", FW'({done0, done1}), FW'(2'b01));
        req1 = 1'b0;
        wait_fv(n);
        check("pair3_fin0", fin, fc);
        reply(8'h05);
        wait_done(n);
        check("pair3_done_sel0", FW'({done0, done1}), FW'(2'b10));
        req0 = 1'b0;
        tick(); tick();
        check("idle_busy", FW'(busy), FW'(1'b0));

        // Single request, OK reply: strobe at 3 cycles, done after GAP.
        frame0 = fa;
        req0 = 1'b1;
        tick(); tick();
        check("ok_fv_early", FW'(fin_valid), FW'(1'b0));
        check("ok_busy", FW'(busy), FW'(1'b1));
        tick();
        check("ok_fv", FW'(fin_valid), FW'(1'b1));
        check("ok_fin", fin, fa);
        reply(8'h05);
        for (int i = 0; i < GAP - 1; i++) tick();
        check("ok_done_early", FW'(done0), FW'(1'b0));
        tick();
        check("ok_done0", FW'(done0), FW'(1'b1));
        check("ok_status", FW'(status), FW'(2'b00));
        check("ok_no_fv_with_done", FW'(fin_valid), FW'(1'b0));
        req0 = 1'b0;
        tick();
        check("ok_done_pulse", FW'(done0), FW'(1'b0));
        tick();

        // Four ERROR replies: 4 strobes, then status ERROR.
        base = fv_total;
        req0 = 1'b1;
        wait_fv(n);
        for (int i = 0; i < 4; i++) begin
            reply(8'h04);
            if (i < 3) begin
                wait_fv(n);
                check("err_retx_gap", FW'(n), FW'(GAP + 1));
            end
        end
        wait_done(n);
        check("err_done_lat", FW'(n), FW'(GAP));
        check("err_status", FW'(status), FW'(2'b01));
        check("err_strobes", FW'(fv_total - base), FW'(4));
        req0 = 1'b0;
        tick(); tick();

        // ERROR then OK, with req dropped mid-transfer (odd code counts as ERROR).
        base = fv_total;
        req1 = 1'b1;
        wait_fv(n);
        req1 = 1'b0;
        reply(8'h33);
        wait_fv(n);
        check("retx_gap", FW'(n), FW'(GAP + 1));
        check("retx_fin", fin, fb);
        reply(8'h05);
        wait_done(n);
        check("retx_done1", FW'({done0, done1}), FW'(2'b01));
        check("retx_status", FW'(status), FW'(2'b00));
        check("retx_strobes", FW'(fv_total - base), FW'(2));
        tick(); tick();

        // No confirmation: TIMEOUT status exactly TIMEOUT+GAP after the strobe.
        req0 = 1'b1;
        wait_fv(n);
        wait_done(n);
        check("tmo_lat", FW'(n), FW'(TIMEOUT + GAP));
        check("tmo_status", FW'(status), FW'(2'b11));
        req0 = 1'b0;
        tick(); tick();

        // FATAL: no retransmit.
        base = fv_total;
        req0 = 1'b1;
        wait_fv(n);
        reply(8'h08);
        wait_done(n);
        check("fatal_lat", FW'(n), FW'(GAP));
        check("fatal_status", FW'(status), FW'(2'b10));
        check("fatal_strobes", FW'(fv_total - base), FW'(1));
        req0 = 1'b0;
        tick(); tick();

        // rx_busy holds the strobe off until the cycle after it falls.
        rx_busy = 1'b1;
        req0 = 1'b1;
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fin_valid) quiet++;
        end
        check("rxb_withheld", FW'(quiet), FW'(0));
        rx_busy = 1'b0;
        tick();
        check("rxb_fv", FW'(fin_valid), FW'(1'b1));

        // Reset while waiting for confirmation: transfer discarded.
        tick(); tick(); tick();
        base = dn_total;
        rst_n = 1'b0;
        #1;
        check("mid_rst_fin", fin, '0);
        check("mid_rst_busy", FW'(busy), FW'(1'b0));
        check("mid_rst_outs", FW'({fin_valid, done0, done1, status}), FW'(5'b0));
        req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < TIMEOUT + GAP + 20; i++) tick();
        check("mid_rst_no_done", FW'(dn_total - base), FW'(0));
        check("mid_rst_idle", FW'(busy), FW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
